fetch_unit: RTL and testbench

//  Instruction fetch stage; sits directly upstream of decode and supplies the instruction word it latches each posedge.

---
 rtl/rv_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants for the instruction fetch slice
//
// Purpose: default datapath width, reset PC and the canonical NOP encoding
//          (addi x0, x0, 0) that fetch presents to decode when it has no
//          valid instruction.
// Ports:   none (package).
package rv_pkg;

  localparam int          WORD_SIZE_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-stage bus bundle (imem, redirect, decode)
//
// Purpose: groups the instruction-memory request/response channel, the
//          control-flow redirect input and the decode-facing instruction
//          stream into one bundle.
// Ports:   master - the fetch unit (drives imem requests and the instruction
//                   stream, receives responses, redirects, instr_ready)
//          slave  - the environment (memory, branch unit, decode)
interface fetch_unit_if #(
  parameter int WORD_SIZE = 32
);

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [WORD_SIZE-1:0] imem_req_addr;
  logic                 imem_resp_valid;
  logic [WORD_SIZE-1:0] imem_resp_data;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [WORD_SIZE-1:0] instruction;
  logic [WORD_SIZE-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instruction, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instruction, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - pointer-based prefetch FIFO with flush
//
// Purpose: holds fetched {instruction, pc} entries between memory and decode.
//          Push and pop in the same cycle are allowed even when full; flush
//          empties the FIFO and overrides any push/pop in that cycle.
// Ports:   clock, reset_n         - clock, async active-low reset
//          push, push_data        - write an entry (ignored if full without pop)
//          pop                    - drop the head entry (ignored if empty)
//          flush                  - discard all entries
//          head_data              - current head entry (undefined when empty)
//          empty, full, count     - occupancy status
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO can still accept when the head leaves in the same cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch FIFO and redirect
//
// Purpose: owns the PC, issues word reads to instruction memory under a
//          credit limit, buffers returned words in a prefetch FIFO and
//          presents them to decode as a valid/ready stream. A redirect
//          restarts fetch at a new PC and discards every fetch still in
//          flight.
// Ports:   clock, reset_n - clock, async active-low reset
//          bus (master)   - imem_req_*/imem_resp_* memory channel,
//                           redirect_valid/redirect_pc, and the decode
//                           stream instr_valid/instr_ready/instruction/instr_pc
module fetch_unit
  import rv_pkg::*;
#(
  parameter int                   WORD_SIZE  = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = WORD_SIZE'(RESET_PC_DEF),
  parameter int                   FIFO_DEPTH = 2
) (
  input logic          clock,
  input logic          reset_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int EW = 2 * WORD_SIZE;

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic                 started_q, started_d;

  logic [EW-1:0]        head;
  logic                 fifo_empty, fifo_full;
  logic [CW-1:0]        occ;

  logic                 credit, req_valid, req_fire;
  logic                 resp_drop, push, pop;
  logic [WORD_SIZE-1:0] redirect_target;

  always_comb begin
    // Buffered plus in-flight words may never exceed FIFO capacity, so every
    // response always has a slot waiting for it.
    credit          = ({1'b0, occ} + {1'b0, outst_q}) < SW'(FIFO_DEPTH);
    // started_q holds off the first request until one cycle after reset.
    req_valid       = started_q && !bus.redirect_valid && credit;
    req_fire        = req_valid && bus.imem_req_ready;
    resp_drop       = bus.imem_resp_valid && (drop_q != '0);
    push            = bus.imem_resp_valid && !resp_drop;
    pop             = !fifo_empty && bus.instr_ready;
    redirect_target = bus.redirect_pc & ~WORD_SIZE'(3);

    started_d = 1'b1;
    pc_d      = req_fire ? pc_q + WORD_SIZE'(4) : pc_q;
    resp_pc_d = push ? resp_pc_q + WORD_SIZE'(4) : resp_pc_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
    drop_d    = drop_q - CW'(resp_drop);

    if (bus.redirect_valid) begin
      pc_d      = redirect_target;
      resp_pc_d = redirect_target;
      // Everything still outstanding after this cycle belongs to the old path.
      drop_d    = outst_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      started_q <= started_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({bus.imem_resp_data, resp_pc_q}),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (occ)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = !fifo_empty;
  assign bus.instruction    = fifo_empty ? WORD_SIZE'(NOP_INSTR) : head[EW-1:WORD_SIZE];
  assign bus.instr_pc       = fifo_empty ? '0 : head[WORD_SIZE-1:0];

  a_credit: assert property (@(posedge clock) disable iff (!reset_n)
    ({1'b0, occ} + {1'b0, outst_q}) <= SW'(FIFO_DEPTH));
  a_drop: assert property (@(posedge clock) disable iff (!reset_n)
    drop_q <= outst_q);
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int DEPTH = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if #(.WORD_SIZE(32)) bus();

  fetch_unit #(
    .WORD_SIZE  (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks   = 0;
  int          passes   = 0;
  int          fails    = 0;
  int          cycle    = 0;
  int          last_due = 0;
  int          consumed = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  logic [31:0] req_exp, cons_exp, last_cons_pc, a0;
  mreq_t       mq[$];
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate the cycle at the negedge against the reference
  // model, let the edge happen, then drive the memory response for the next cycle.
  task automatic tick();
    logic  fire, pop, redir;
    mreq_t m;
    int    lat;
    @(negedge clock);
    redir = bus.redirect_valid;
    fire  = bus.imem_req_valid && bus.imem_req_ready;
    pop   = bus.instr_valid && bus.instr_ready;
    if (!bus.instr_valid) begin
      check("idle_instruction", bus.instruction, NOP_INSTR);
      check("idle_instr_pc", bus.instr_pc, 32'h0);
    end
    if (redir) check("no_req_in_redirect", {31'b0, bus.imem_req_valid}, 32'h0);
    if (fire) begin
      check("req_addr", bus.imem_req_addr, req_exp);
      req_log.push_back(bus.imem_req_addr);
      req_exp += 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      m.addr = bus.imem_req_addr;
      m.due  = cycle + lat;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mq.push_back(m);
    end
    if (pop && !redir) begin
      check("instr_pc", bus.instr_pc, cons_exp);
      check("instruction", bus.instruction, mem_word(cons_exp));
      last_cons_pc = bus.instr_pc;
      cons_exp += 32'd4;
      consumed++;
    end
    if (redir) begin
      req_exp  = bus.redirect_pc & ~32'd3;
      cons_exp = bus.redirect_pc & ~32'd3;
      req_log.delete();
    end
    if (bus.imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
    check("inflight_bound", {31'b0, mq.size() <= DEPTH}, 32'h1);
    @(posedge clock);
    #1;
    cycle++;
    if (mq.size() > 0 && mq[0].due <= cycle) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'h0);
    check({tag, "_instr_valid"}, {31'b0, bus.instr_valid}, 32'h0);
    check({tag, "_instruction"}, bus.instruction, NOP_INSTR);
    check({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
  endtask

  initial begin
    int n0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b1;
    req_exp      = 32'h0;
    cons_exp     = 32'h0;
    last_cons_pc = 32'h0;

    // Reset state and first request one cycle after release
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("first_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    check("first_req_addr", bus.imem_req_addr, 32'h0);

    // 1: sequential stream with 1-cycle memory
    for (int i = 0; i < 40 && consumed < 8; i++) tick();
    check("stream_progress", {31'b0, consumed >= 8}, 32'h1);
    check("stream_8th_pc", last_cons_pc, 32'h1C);

    // 2: decode stalls; FIFO fills, requests stop, nothing lost
    bus.instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_stopped", {31'b0, bus.imem_req_valid}, 32'h0);
    check("stall_head_valid", {31'b0, bus.instr_valid}, 32'h1);
    check("stall_no_inflight", mq.size(), 32'h0);
    check("stall_head_pc", bus.instr_pc, cons_exp);
    bus.instr_ready = 1'b1;
    repeat (6) tick();

    // 3: redirect with two fetches in flight
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && mq.size() != 2; i++) tick();
    check("two_in_flight", mq.size(), 32'h2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    n0 = consumed;
    for (int i = 0; i < 30 && consumed == n0; i++) tick();
    check("redirect_first_pc", last_cons_pc, 32'h100);
    // back-to-back redirects: the last one wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_pc    = 32'h304;
    tick();
    bus.redirect_valid = 1'b0;
    n0 = consumed;
    for (int i = 0; i < 30 && consumed == n0; i++) tick();
    check("b2b_redirect_pc", last_cons_pc, 32'h304);
    lat_min = 1;
    lat_max = 1;
    repeat (8) tick();

    // 4: memory back-pressure; address held, stream drains to NOP
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    a0 = bus.imem_req_addr;
    check("hold_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_addr_stable", bus.imem_req_addr, a0);
      check("hold_valid_stable", {31'b0, bus.imem_req_valid}, 32'h1);
    end
    check("drain_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("drain_instruction", bus.instruction, NOP_INSTR);
    bus.imem_req_ready = 1'b1;

    // 5: PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 20 && req_log.size() < 3; i++) tick();
    if (req_log.size() >= 3) begin
      check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", req_log[2], 32'h0000_0000);
    end else begin
      check("wrap_req_count", req_log.size(), 32'h3);
    end
    repeat (4) tick();

    // 6: reset asserted mid-stream with a full FIFO
    bus.instr_ready = 1'b0;
    repeat (6) tick();
    check("full_head_valid", {31'b0, bus.instr_valid}, 32'h1);
    check("full_req_stopped", {31'b0, bus.imem_req_valid}, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mq.delete();
    req_log.delete();
    last_due = 0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.instr_ready     = 1'b1;
    req_exp  = 32'h0;
    cons_exp = 32'h0;
    tick();
    reset_n = 1'b1;
    tick();
    check("restart_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    check("restart_req_addr", bus.imem_req_addr, 32'h0);

    // Randomized traffic against the reference model
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      bus.imem_req_ready = ($urandom % 4) != 0;
      bus.instr_ready    = ($urandom % 10) < 7;
      if (($urandom % 20) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    repeat (10) tick();
    check("overall_progress", {31'b0, consumed > 60}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
